// File: rtl/shrimp_program_counter.sv
// Fetch-address generator with step/jump/branch/stall and a circular RAS.
// Define SHRIMP_PC_ALIGN_CHECK_EN to reject targets not aligned to STEP.
module shrimp_program_counter #(
  parameter int ADDR_WIDTH = 16,
  parameter int STEP       = 2,
  parameter int RESET_ADDR = 0,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           jump,
  input  logic [ADDR_WIDTH-1:0]          jump_addr,
  input  logic                           branch,
  input  logic [ADDR_WIDTH-1:0]          branch_offset,
  input  logic                           call,
  input  logic                           ret,
  output logic [ADDR_WIDTH-1:0]          instruction_address,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow,
  output logic                           misalign_error
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [AW-1:0] STEP_W    = AW'(STEP);
  localparam logic [AW-1:0] STEP_MASK = AW'(STEP - 1);
  localparam logic [AW-1:0] RST_W     = AW'(RESET_ADDR);
  localparam logic [CW-1:0] FULL_CNT  = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] LAST_IDX  = PW'(RAS_DEPTH - 1);

`ifdef SHRIMP_PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;

  logic [AW-1:0] pc;
  logic [AW-1:0] seq_addr;
  logic [AW-1:0] br_addr;
  logic [AW-1:0] tgt;
  logic [AW-1:0] pc_nxt;

  logic ras_empty;
  logic ras_full;
  logic do_ret;
  logic do_call;
  logic do_jump;
  logic do_branch;
  logic redirect;
  logic misalign;
  logic push;
  logic pop;
  logic ovf_set;
  logic unf_set;

  assign instruction_address = pc;

  assign seq_addr  = pc + STEP_W;
  assign br_addr   = pc + branch_offset;
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == FULL_CNT);
  assign ptr_inc   = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
  assign ptr_dec   = (ptr == '0) ? LAST_IDX : ptr - 1'b1;

  // Priority is folded into one-hot selects: ret > call > jump > branch.
  assign do_ret    = ret;
  assign do_call   = call & ~ret;
  assign do_jump   = jump & ~ret & ~call;
  assign do_branch = branch & ~ret & ~call & ~jump;

  always_comb begin
    tgt      = seq_addr;
    redirect = 1'b0;
    pop      = 1'b0;
    push     = 1'b0;
    unf_set  = 1'b0;
    ovf_set  = 1'b0;
    unique case (1'b1)
      do_ret: begin
        if (ras_empty) begin
          unf_set = 1'b1;
        end else begin
          pop      = 1'b1;
          tgt      = ras_mem[ptr_dec];
          redirect = 1'b1;
        end
      end
      do_call: begin
        push     = 1'b1;
        ovf_set  = ras_full;
        tgt      = jump_addr;
        redirect = 1'b1;
      end
      do_jump: begin
        tgt      = jump_addr;
        redirect = 1'b1;
      end
      do_branch: begin
        tgt      = br_addr;
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

  // A rejected target falls through; a rejected ret has already popped.
  assign misalign = ALIGN_EN && redirect
                 && ((tgt & STEP_MASK) != '0);

  always_comb begin
    pc_nxt = misalign ? seq_addr : tgt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RST_W;
      ptr           <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (!stall) begin
      pc <= pc_nxt;
      if (unf_set) ras_underflow <= 1'b1;
      if (pop) begin
        ptr       <= ptr_dec;
        ras_count <= ras_count - 1'b1;
      end else if (push && !misalign) begin
        ptr <= ptr_inc;
        if (ovf_set) ras_overflow <= 1'b1;
        else         ras_count    <= ras_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !stall && push && !misalign) begin
      ras_mem[ptr] <= seq_addr;
    end
  end

`ifdef SHRIMP_PC_ALIGN_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      misalign_error <= 1'b0;
    end else if (!stall && misalign) begin
      misalign_error <= 1'b1;
    end
  end
`else
  assign misalign_error = 1'b0;
`endif

endmodule

// File: tb/tb_shrimp_program_counter.sv
// Directed bench for shrimp_program_counter (default parameters).
// Define SHRIMP_PC_ALIGN_CHECK_EN to check the alignment-reject build.
module tb_shrimp_program_counter;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [15:0] jump_addr;
  logic        branch;
  logic [15:0] branch_offset;
  logic        call;
  logic        ret;
  logic [15:0] instruction_address;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        misalign_error;

  int checks = 0;
  int errors = 0;

  shrimp_program_counter dut (
    .clock               (clock),
    .reset               (reset),
    .stall               (stall),
    .jump                (jump),
    .jump_addr           (jump_addr),
    .branch              (branch),
    .branch_offset       (branch_offset),
    .call                (call),
    .ret                 (ret),
    .instruction_address (instruction_address),
    .ras_count           (ras_count),
    .ras_overflow        (ras_overflow),
    .ras_underflow       (ras_underflow),
    .misalign_error      (misalign_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [15:0] a);
    jump = 1'b1;
    jump_addr = a;
    tick();
    jump = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    jump = 1'b0;
    jump_addr = '0;
    branch = 1'b0;
    branch_offset = '0;
    call = 1'b0;
    ret = 1'b0;

    // reset and sequential stepping
    tick();
    check("rst_pc", 32'(instruction_address), 32'h0000);
    check("rst_cnt", 32'(ras_count), 0);
    check("rst_ovf", 32'(ras_overflow), 0);
    check("rst_unf", 32'(ras_underflow), 0);
    check("rst_mis", 32'(misalign_error), 0);
    reset = 1'b0;
    tick();
    check("step1", 32'(instruction_address), 32'h0002);
    tick();
    check("step2", 32'(instruction_address), 32'h0004);
    tick();
    check("step3", 32'(instruction_address), 32'h0006);
    reset = 1'b1;
    tick();
    check("rst_again", 32'(instruction_address), 32'h0000);
    reset = 1'b0;

    // negative branch and silent wrap
    go(16'h0010);
    check("jmp10", 32'(instruction_address), 32'h0010);
    branch = 1'b1;
    branch_offset = 16'hFFF0;
    tick();
    branch = 1'b0;
    check("br_neg", 32'(instruction_address), 32'h0000);
    go(16'hFFFE);
    check("jmpFFFE", 32'(instruction_address), 32'hFFFE);
    tick();
    check("wrap_pc", 32'(instruction_address), 32'h0000);
    check("wrap_ovf", 32'(ras_overflow), 0);
    check("wrap_unf", 32'(ras_underflow), 0);
    check("wrap_mis", 32'(misalign_error), 0);

    // single call/return
    go(16'h0100);
    call = 1'b1;
    jump_addr = 16'h0400;
    tick();
    call = 1'b0;
    check("call_pc", 32'(instruction_address), 32'h0400);
    check("call_cnt", 32'(ras_count), 1);
    tick();
    check("idle1", 32'(instruction_address), 32'h0402);
    tick();
    check("idle2", 32'(instruction_address), 32'h0404);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("ret_pc", 32'(instruction_address), 32'h0102);
    check("ret_cnt", 32'(ras_count), 0);

    // nested calls past depth, then drain past empty
    go(16'h0000);
    call = 1'b1;
    jump_addr = 16'h1000;
    tick();
    check("n1_cnt", 32'(ras_count), 1);
    jump_addr = 16'h2000;
    tick();
    jump_addr = 16'h3000;
    tick();
    jump_addr = 16'h4000;
    tick();
    check("n4_cnt", 32'(ras_count), 4);
    check("n4_ovf", 32'(ras_overflow), 0);
    jump_addr = 16'h5000;
    tick();
    call = 1'b0;
    check("n5_pc", 32'(instruction_address), 32'h5000);
    check("n5_cnt", 32'(ras_count), 4);
    check("n5_ovf", 32'(ras_overflow), 1);
    ret = 1'b1;
    tick();
    check("pop1", 32'(instruction_address), 32'h4002);
    tick();
    check("pop2", 32'(instruction_address), 32'h3002);
    tick();
    check("pop3", 32'(instruction_address), 32'h2002);
    tick();
    check("pop4", 32'(instruction_address), 32'h1002);
    check("pop4_cnt", 32'(ras_count), 0);
    check("pop4_unf", 32'(ras_underflow), 0);
    tick();
    ret = 1'b0;
    check("pop5_pc", 32'(instruction_address), 32'h1004);
    check("pop5_cnt", 32'(ras_count), 0);
    check("pop5_unf", 32'(ras_underflow), 1);

    // stall beats jump; ret beats call
    go(16'h0020);
    stall = 1'b1;
    jump = 1'b1;
    jump_addr = 16'h0800;
    tick();
    check("stall1", 32'(instruction_address), 32'h0020);
    tick();
    check("stall2", 32'(instruction_address), 32'h0020);
    stall = 1'b0;
    tick();
    jump = 1'b0;
    check("unstall", 32'(instruction_address), 32'h0800);
    call = 1'b1;
    jump_addr = 16'h0900;
    tick();
    jump_addr = 16'h0A00;
    tick();
    call = 1'b0;
    check("c2_pc", 32'(instruction_address), 32'h0A00);
    check("c2_cnt", 32'(ras_count), 2);
    stall = 1'b1;
    ret = 1'b1;
    tick();
    stall = 1'b0;
    check("stall_ret_pc", 32'(instruction_address), 32'h0A00);
    check("stall_ret_cnt", 32'(ras_count), 2);
    call = 1'b1;
    jump_addr = 16'h0B00;
    tick();
    call = 1'b0;
    check("cr_pc", 32'(instruction_address), 32'h0902);
    check("cr_cnt", 32'(ras_count), 1);
    tick();
    ret = 1'b0;
    check("cr_pop", 32'(instruction_address), 32'h0802);
    check("cr_cnt0", 32'(ras_count), 0);
    check("sticky_ovf", 32'(ras_overflow), 1);
    check("sticky_unf", 32'(ras_underflow), 1);

    // misaligned jump target
    go(16'h0040);
    go(16'h0301);
`ifdef SHRIMP_PC_ALIGN_CHECK_EN
    check("mis_pc", 32'(instruction_address), 32'h0042);
    check("mis_flag", 32'(misalign_error), 1);
`else
    check("mis_pc", 32'(instruction_address), 32'h0301);
    check("mis_flag", 32'(misalign_error), 0);
`endif

    // reset clears sticky flags
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("end_pc", 32'(instruction_address), 32'h0000);
    check("end_ovf", 32'(ras_overflow), 0);
    check("end_unf", 32'(ras_underflow), 0);
    check("end_mis", 32'(misalign_error), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/shrimp_program_counter.md
Name: shrimp_program_counter

Overview:
Parametrised successor to the basic instruction counter. Produces the fetch address each cycle, with these control inputs:
- sequential step
- absolute jump
- PC-relative branch
- stall
- call/return, backed by an internal return-address stack (RAS)

It sits between the decoder/branch unit and instruction fetch.

Parameters:
- ADDR_WIDTH, 16: width of all addresses and of the branch offset.
- STEP, 2: sequential increment in bytes. Must be a power of two and ≥ 1.
- RESET_ADDR, 0: value loaded into instruction_address on reset.
- RAS_DEPTH, 4: number of return-stack entries. Must be ≥ 1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; applied on the rising edge of clock.
- stall  in  1  hold the PC and the RAS unchanged this cycle.
- jump  in  1  load jump_addr.
- jump_addr  in  ADDR_WIDTH  absolute target used by jump and call.
- branch  in  1  take a PC-relative branch.
- branch_offset  in  ADDR_WIDTH  signed two's-complement offset, relative to the current instruction_address.
- call  in  1  push return address, then go to jump_addr.
- ret  in  1  pop return address into the PC.
- instruction_address  out  ADDR_WIDTH  current fetch address (registered).
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_overflow  out  1  sticky flag: a call was made with the RAS full.
- ras_underflow  out  1  sticky flag: a ret was made with the RAS empty.
- misalign_error  out  1  sticky flag; see Optional Feature.

Behaviour:
- Reset, on the rising edge:
  - instruction_address = RESET_ADDR.
  - ras_count = 0; RAS contents are don't-care.
  - All sticky flags = 0.
  - Reset overrides every other input.
- Per-cycle priority (exactly one action per edge): reset > stall > ret > call > jump > branch > step.
- stall: instruction_address, RAS and flags hold their values; all other controls are ignored.
- ret:
  - RAS non-empty: PC <= top entry; ras_count decrements.
  - RAS empty: PC <= PC + STEP; ras_underflow <= 1; ras_count stays 0.
- call:
  - Push (PC + STEP) mod 2^ADDR_WIDTH; PC <= jump_addr.
  - RAS full: the oldest entry is discarded (circular overwrite), ras_count stays RAS_DEPTH, ras_overflow <= 1.
  - The newest RAS_DEPTH return addresses are always preserved in LIFO order.
- jump: PC <= jump_addr.
- branch: PC <= (PC + branch_offset) mod 2^ADDR_WIDTH, with branch_offset sign-interpreted.
- No control asserted: PC <= (PC + STEP) mod 2^ADDR_WIDTH.
- Arithmetic: all address arithmetic is ADDR_WIDTH bits and wraps silently. Wrap is not an error.
- Latency: every control takes effect on the next rising edge. instruction_address has no combinational path from any input.
- Sticky flags clear only on reset.
- Simultaneous call and ret: ret wins. Call is dropped and no push occurs.

Optional Feature:
Macro SHRIMP_PC_ALIGN_CHECK_EN.
- Defined:
  - Any jump, call, branch or ret target with (target mod STEP) != 0 is rejected.
  - On rejection: PC <= PC + STEP, misalign_error <= 1 (sticky), RAS unchanged.
  - A rejected ret still pops its entry.
- Undefined:
  - Targets are used as-is.
  - misalign_error is tied to 0.

Test Plan:
1. Reset, then 3 idle cycles with defaults → instruction_address 0x0000, 0x0002, 0x0004, 0x0006. Assert reset at PC 0x0006 → next edge 0x0000.
2. At PC 0x0010: branch with offset 0xFFF0 (−16) → 0x0000. At PC 0xFFFE, idle → wraps to 0x0000, no flag raised.
3. At PC 0x0100: call to 0x0400, then idle twice, then ret → 0x0400, 0x0402, 0x0404, 0x0102, with ras_count 1→0.
4. Five nested calls (RAS_DEPTH=4) from 0x0000, 0x1000, 0x2000, 0x3000, 0x4000 to those successive targets → ras_overflow=1, ras_count=4. Four rets return 0x4002, 0x3002, 0x2002, 0x1002; a fifth ret gives PC+2 and ras_underflow=1.
5. stall held 2 cycles together with jump=1, jump_addr 0x0800 at PC 0x0020 → PC stays 0x0020. Drop stall with jump still asserted → 0x0800. In the same cycle as call and ret with 2 valid entries → ret wins, ras_count 2→1.
6. With SHRIMP_PC_ALIGN_CHECK_EN defined: jump to 0x0301 at PC 0x0040 → PC 0x0042, misalign_error=1. Without the macro, the same stimulus gives PC 0x0301, misalign_error=0.
